// File: rtl/video_stream_src_if.sv
// Gray-image video stream: frame-valid, pixel-valid and pixel data.
// The source drives the master modport; point-processing sinks take the slave modport.
interface video_stream_src_if #(
  parameter int DATA_W = 8
);
  logic              per_img_vsync;
  logic              per_img_href;
  logic [DATA_W-1:0] per_img_gray;

  modport master (output per_img_vsync, output per_img_href, output per_img_gray);
  modport slave  (input  per_img_vsync, input  per_img_href, input  per_img_gray);
endinterface

// File: rtl/video_stream_src.sv
// Frame source: reads one frame from a synchronous-read pixel RAM on each start request.
// Drives a gray video stream with fixed vertical lead-in and horizontal blanking.
module video_stream_src #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int V_LEAD     = 10,
  parameter int H_BLANK    = 10,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  video_stream_src_if.master vid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int BMAX = (V_LEAD > H_BLANK) ? V_LEAD : H_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] LEAD_LAST  = BW'(V_LEAD - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(H_BLANK - 1);

  typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLK, TAIL} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   blank_cnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            fsm_vsync, fsm_rd_en;
  logic            vsync_q, href_q;

  // A new frame is only accepted once the previous one has fully left the
  // output register, so back-to-back frames keep a two-cycle vsync gap.
  always_comb begin
    state_nxt = state;
    fsm_vsync = 1'b0;
    fsm_rd_en = 1'b0;
    case (state)
      IDLE: if (start && !vsync_q) state_nxt = LEAD;
      LEAD: begin
        fsm_vsync = 1'b1;
        if (blank_cnt == LEAD_LAST) state_nxt = LINE;
      end
      LINE: begin
        fsm_vsync = 1'b1;
        fsm_rd_en = 1'b1;
        if (col == COL_LAST) state_nxt = (row == ROW_LAST) ? TAIL : HBLK;
      end
      HBLK: begin
        fsm_vsync = 1'b1;
        if (blank_cnt == BLANK_LAST) state_nxt = LINE;
      end
      TAIL: begin
        fsm_vsync = 1'b1;
        if (blank_cnt == BLANK_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blank_cnt <= '0;
      col       <= '0;
      row       <= '0;
      rd_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        blank_cnt <= '0;
      else if (state inside {LEAD, HBLK, TAIL})
        blank_cnt <= blank_cnt + 1'b1;
      if (fsm_rd_en)
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      if (state == IDLE)
        row <= '0;
      else if (state == HBLK && state_nxt == LINE)
        row <= row + 1'b1;
      // Linear address walks the image row-major, so no row*width product is needed.
      if (state == IDLE)
        rd_addr <= '0;
      else if (fsm_rd_en)
        rd_addr <= rd_addr + 1'b1;
    end
  end

  // Outputs lag the FSM by one cycle so href lines up with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vsync_q <= fsm_vsync;
      href_q  <= fsm_rd_en;
      done    <= vsync_q & ~fsm_vsync;
      if (vsync_q && !fsm_vsync)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign rd_en             = fsm_rd_en;
  assign busy              = (state != IDLE) | vsync_q | done;
  assign vid.per_img_vsync = vsync_q;
  assign vid.per_img_href  = href_q;
  assign vid.per_img_gray  = href_q ? rd_data : '0;

endmodule

// File: tb/tb_video_stream_src.sv
// Bench for video_stream_src: a 4x3 instance checked cycle by cycle against an arithmetic
// frame model, plus a 64x48 instance streaming a random image.
module tb_video_stream_src;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int VL     = 3;
  localparam int HB     = 2;
  localparam int VS_LEN = VL + H * W + H * HB;
  localparam int P      = VS_LEN + 2;

  localparam int LW      = 64;
  localparam int LH      = 48;
  localparam int L_VSLEN = 10 + LW * LH + LH * 10;

  logic clk = 1'b0;
  logic rst_n;
  logic s_start, l_start;

  logic        s_rd_en, s_busy, s_done;
  logic [18:0] s_rd_addr;
  logic [7:0]  s_rd_data;
  logic [15:0] s_frame_cnt;
  logic        l_rd_en, l_busy, l_done;
  logic [18:0] l_rd_addr;
  logic [7:0]  l_rd_data;
  logic [15:0] l_frame_cnt;

  logic [7:0] mem_s [0:15];
  logic [7:0] mem_l [0:4095];

  int checks = 0;
  int errors = 0;

  video_stream_src_if #(.DATA_W(8)) s_vid ();
  video_stream_src_if #(.DATA_W(8)) l_vid ();

  video_stream_src #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .V_LEAD(VL), .H_BLANK(HB), .DATA_W(8), .ADDR_W(19)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .vid(s_vid), .busy(s_busy), .done(s_done), .frame_cnt(s_frame_cnt)
  );

  video_stream_src #(
    .IMG_WIDTH(LW), .IMG_HEIGHT(LH), .V_LEAD(10), .H_BLANK(10), .DATA_W(8), .ADDR_W(19)
  ) dut_large (
    .clk(clk), .rst_n(rst_n), .start(l_start), .rd_en(l_rd_en), .rd_addr(l_rd_addr),
    .rd_data(l_rd_data), .vid(l_vid), .busy(l_busy), .done(l_done), .frame_cnt(l_frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel RAMs: data appears the cycle after the read strobe.
  always @(posedge clk) if (s_rd_en) s_rd_data <= mem_s[s_rd_addr[3:0]];
  always @(posedge clk) if (l_rd_en) l_rd_data <= mem_l[l_rd_addr[11:0]];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    s_start = 1'b1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit pix_on(input int p);
    return (p >= 0) && (p / (W + HB) < H) && (p % (W + HB) < W);
  endfunction

  function automatic int pix_idx(input int p);
    return (p / (W + HB)) * W + (p % (W + HB));
  endfunction

  // k counts cycles after the edge that samples the first start; frames repeat every P cycles.
  task automatic checkStream(input int nframes, input int pulse_k, input int base_cnt);
    int f, j, total, bursts, vs_high, ndone;
    bit exp_vs, exp_href, exp_rden;
    logic prev_href;
    total = nframes * P + 6;
    bursts = 0;
    vs_high = 0;
    prev_href = 1'b0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == (nframes - 1) * P) s_start = 1'b0;
      if (pulse_k >= 0 && k == pulse_k) s_start = 1'b1;
      if (pulse_k >= 0 && k == pulse_k + 1) s_start = 1'b0;
      f = k / P;
      if (f > nframes - 1) f = nframes - 1;
      j = k - f * P;
      exp_vs   = (j >= 1) && (j <= VS_LEN);
      exp_href = pix_on(j - 1 - VL);
      exp_rden = pix_on(j - VL);
      ndone = 0;
      for (int g = 0; g < nframes; g++) if (g * P + VS_LEN + 1 <= k) ndone++;
      checkOutput($sformatf("vsync k=%0d", k), 32'(s_vid.per_img_vsync), 32'(exp_vs));
      checkOutput($sformatf("href k=%0d", k), 32'(s_vid.per_img_href), 32'(exp_href));
      checkOutput($sformatf("gray k=%0d", k), 32'(s_vid.per_img_gray),
                  exp_href ? 32'(8'h10 + pix_idx(j - 1 - VL)) : 32'd0);
      checkOutput($sformatf("rd_en k=%0d", k), 32'(s_rd_en), 32'(exp_rden));
      if (exp_rden)
        checkOutput($sformatf("rd_addr k=%0d", k), 32'(s_rd_addr), 32'(pix_idx(j - VL)));
      checkOutput($sformatf("done k=%0d", k), 32'(s_done), 32'(j == VS_LEN + 1));
      checkOutput($sformatf("busy k=%0d", k), 32'(s_busy), 32'(j <= VS_LEN + 1));
      checkOutput($sformatf("frame_cnt k=%0d", k), 32'(s_frame_cnt), 32'(base_cnt + ndone));
      if (s_vid.per_img_href === 1'b1 && prev_href !== 1'b1) bursts++;
      if (s_vid.per_img_vsync === 1'b1) vs_high++;
      prev_href = s_vid.per_img_href;
    end
    checkOutput("href_bursts", 32'(bursts), 32'(H * nframes));
    checkOutput("vsync_cycles", 32'(vs_high), 32'(VS_LEN * nframes));
  endtask

  initial begin
    int pulse, pix, bursts, vs_high;
    bit seen_done;
    logic prev_href;

    rst_n   = 1'b0;
    s_start = 1'b0;
    l_start = 1'b0;
    for (int i = 0; i < 16; i++) mem_s[i] = 8'(8'h10 + i);
    for (int i = 0; i < 4096; i++) mem_l[i] = 8'($urandom);

    #1;
    checkOutput("reset vsync", 32'(s_vid.per_img_vsync), 32'd0);
    checkOutput("reset href", 32'(s_vid.per_img_href), 32'd0);
    checkOutput("reset gray", 32'(s_vid.per_img_gray), 32'd0);
    checkOutput("reset rd_en", 32'(s_rd_en), 32'd0);
    checkOutput("reset rd_addr", 32'(s_rd_addr), 32'd0);
    checkOutput("reset busy", 32'(s_busy), 32'd0);
    checkOutput("reset done", 32'(s_done), 32'd0);
    checkOutput("reset frame_cnt", 32'(s_frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single frame and latency");
    applyStimulus();
    checkStream(1, -1, 0);

    $display("[TB] start while busy");
    doReset();
    pulse = $urandom_range(2, VS_LEN);
    applyStimulus();
    checkStream(1, pulse, 0);

    $display("[TB] continuous start, three frames");
    doReset();
    applyStimulus();
    checkStream(3, -1, 0);

    $display("[TB] reset during line 1");
    applyStimulus();
    for (int k = 0; k <= 1 + VL + (W + HB) + 1; k++) begin
      @(negedge clk);
      if (k == 0) s_start = 1'b0;
    end
    checkOutput("pre-abort vsync", 32'(s_vid.per_img_vsync), 32'd1);
    checkOutput("pre-abort href", 32'(s_vid.per_img_href), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort vsync", 32'(s_vid.per_img_vsync), 32'd0);
    checkOutput("abort href", 32'(s_vid.per_img_href), 32'd0);
    checkOutput("abort gray", 32'(s_vid.per_img_gray), 32'd0);
    checkOutput("abort done", 32'(s_done), 32'd0);
    checkOutput("abort busy", 32'(s_busy), 32'd0);
    checkOutput("abort frame_cnt", 32'(s_frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();
    checkStream(1, -1, 0);

    $display("[TB] 64x48 random image");
    @(negedge clk);
    l_start = 1'b1;
    pix = 0;
    bursts = 0;
    vs_high = 0;
    seen_done = 1'b0;
    prev_href = 1'b0;
    for (int k = 0; k < 5000 && !seen_done; k++) begin
      @(negedge clk);
      l_start = 1'b0;
      if (l_vid.per_img_href === 1'b1) begin
        checkOutput($sformatf("large gray pix=%0d", pix), 32'(l_vid.per_img_gray),
                    32'(mem_l[pix[11:0]]));
        pix++;
      end
      if (l_vid.per_img_href === 1'b1 && prev_href !== 1'b1) bursts++;
      if (l_vid.per_img_vsync === 1'b1) vs_high++;
      prev_href = l_vid.per_img_href;
      if (l_done === 1'b1) seen_done = 1'b1;
    end
    checkOutput("large done seen", 32'(seen_done), 32'd1);
    checkOutput("large pixels", 32'(pix), 32'(LW * LH));
    checkOutput("large bursts", 32'(bursts), 32'(LH));
    checkOutput("large vsync_cycles", 32'(vs_high), 32'(L_VSLEN));
    checkOutput("large frame_cnt", 32'(l_frame_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
